// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, signed or unsigned
// operands chosen per operation, valid/ready handshake on both the operand and product sides.
module booth_mult_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH+1:0]     a_q, a_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [WIDTH:0]       q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH+1:0]     a_sum;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    a_sum   = a_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          // The mode lives on only through the extension bit of M and Q.
          m_d     = {in_signed & in_a[WIDTH-1], in_a};
          q_d     = {in_signed & in_b[WIDTH-1], in_b};
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = CntW'(WIDTH + 1);
          state_d = StRun;
        end
      end
      StRun: begin
        case ({q_q[0], qm1_q})
          2'b01:   a_sum = a_q + {m_q[WIDTH], m_q};
          2'b10:   a_sum = a_q - {m_q[WIDTH], m_q};
          default: a_sum = a_q;
        endcase
        a_d   = {a_sum[WIDTH+1], a_sum[WIDTH+1:1]};
        q_d   = {a_sum[0], q_q[WIDTH:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          p_d     = {a_d[WIDTH-2:0], q_d};
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= StIdle;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_p     = p_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq (WIDTH=8): driver pushes expected products,
// a monitor pops and compares on every product handshake.
module tb_booth_mult_seq;

  localparam int unsigned W = 8;

  logic             clk = 1'b0;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   out_p;
  logic             busy;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];
  time t_acc;

  booth_mult_seq #(.WIDTH(W)) dut (
    .CLOCK_50  (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W-1:0] ea, eb;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  // Returns just after the accepting edge; t_acc records that edge.
  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp, input bit push);
    int n;
    @(negedge clk);
    in_valid  = 1'b1;
    in_signed = s;
    in_a      = a;
    in_b      = b;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", 32'(n), 32'd0);
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    t_acc = $time;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: a product is consumed at the edge after a negedge with valid & ready.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_product", 32'(out_p), 32'hdead);
      end else begin
        check("product", 32'(out_p), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    time t_prev;
    int  k;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_p", 32'(out_p), 32'd0);

    // Latency: -3 x 5 signed, out_valid first seen after edge t0+9.
    issue(1'b1, 8'hFD, 8'h05, 16'hFFF1, 1'b1);
    k = 0;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end while (!out_valid && k < 40);
    check("latency", 32'(k), 32'd9);
    wait_drain();

    // Back-to-back directed vectors; accepts must be WIDTH+3 cycles apart.
    issue(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b1);
    t_prev = t_acc;
    issue(1'b1, 8'h80, 8'h80, 16'h4000, 1'b1);
    check("spacing1", 32'(t_acc - t_prev), 32'((W + 3) * 10));
    t_prev = t_acc;
    issue(1'b0, 8'h80, 8'h80, 16'h4000, 1'b1);
    check("spacing2", 32'(t_acc - t_prev), 32'((W + 3) * 10));
    issue(1'b1, 8'h7F, 8'h80, 16'hC080, 1'b1);
    issue(1'b1, 8'h5A, 8'h00, 16'h0000, 1'b1);
    issue(1'b0, 8'hFF, 8'h01, 16'h00FF, 1'b1);
    issue(1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b1);
    issue(1'b0, 8'h0C, 8'h0D, 16'h009C, 1'b1);
    wait_drain();

    // Backpressure: hold DONE for 20 cycles while in_valid pulses are ignored.
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b1);
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 20; i++) begin
      in_valid  = i[0];
      in_a      = 8'(i * 7);
      in_b      = 8'h33;
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_p", 32'(out_p), 32'h0000FE01);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("consumed_once", 32'(exp_q.size()), 32'd0);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_keeps_p", 32'(out_p), 32'h0000FE01);

    // Reset in the middle of RUN discards the product.
    issue(1'b1, 8'h12, 8'h34, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_p", 32'(out_p), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    issue(1'b1, 8'h7F, 8'h80, 16'hC080, 1'b1);
    wait_drain();

    // Random sweep in both modes against the extended-operand model.
    for (int i = 0; i < 40; i++) begin
      logic          s;
      logic [W-1:0]  a, b;
      s = 1'($urandom_range(0, 1));
      a = W'($urandom);
      b = W'($urandom);
      issue(s, a, b, model(s, a, b), 1'b1);
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
